// File: rtl/collatz_pkg.sv
// Shared types and default sizing for the collatz sweep sequencer.
package collatz_pkg;

  localparam int unsigned N_W_DEF        = 32;
  localparam int unsigned STEP_W_DEF     = 16;
  localparam int unsigned STEP_LIMIT_DEF = 1000;

  typedef enum logic [2:0] {
    IDLE,
    GO,
    WAIT,
    RUN,
    EMIT
  } sweep_state_t;

endpackage

// File: rtl/collatz_max_tracker.sv
// Running maximum of step counts over a sweep; strict-greater, timeouts excluded.
module collatz_max_tracker
  import collatz_pkg::*;
#(
  parameter int unsigned N_W    = N_W_DEF,
  parameter int unsigned STEP_W = STEP_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              update,
  input  logic [N_W-1:0]    cand_n,
  input  logic [STEP_W-1:0] cand_steps,
  input  logic              cand_timeout,
  output logic [N_W-1:0]    max_n,
  output logic [STEP_W-1:0] max_steps
);

  // Replace only on strictly greater steps so ties keep the earlier start value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      max_n     <= '0;
      max_steps <= '0;
    end else if (clear) begin
      max_n     <= '0;
      max_steps <= '0;
    end else if (update && !cand_timeout && (cand_steps > max_steps)) begin
      max_n     <= cand_n;
      max_steps <= cand_steps;
    end
  end

endmodule

// File: rtl/collatz_sweep.sv
// Feeds a range of start values to the collatz iterator, counts steps until
// done, streams (n, steps) results over valid/ready and tracks the maximum.
module collatz_sweep
  import collatz_pkg::*;
#(
  parameter int unsigned N_W        = N_W_DEF,
  parameter int unsigned STEP_W     = STEP_W_DEF,
  parameter int unsigned STEP_LIMIT = STEP_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [N_W-1:0]    first,
  input  logic [STEP_W-1:0] count,
  output logic              it_go,
  output logic [N_W-1:0]    it_n,
  input  logic              it_done,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [N_W-1:0]    res_n,
  output logic [STEP_W-1:0] res_steps,
  output logic              res_timeout,
  output logic              busy,
  output logic              finished,
  output logic [N_W-1:0]    max_n,
  output logic [STEP_W-1:0] max_steps
);

  localparam logic [STEP_W-1:0] LIMIT = STEP_W'(STEP_LIMIT);

  sweep_state_t      state, state_nxt;
  logic [N_W-1:0]    cur;
  logic [STEP_W-1:0] remaining;
  logic [STEP_W-1:0] steps;
  logic              start_ok;
  logic              accept;

  assign start_ok  = (state == IDLE) && start && (count != '0);
  assign accept    = (state == EMIT) && res_ready;
  assign it_go     = (state == GO);
  assign it_n      = cur;
  assign res_valid = (state == EMIT);
  assign busy      = (state != IDLE);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; WAIT exists only to skip the iterator's stale done.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_ok) state_nxt = GO;
      GO:   state_nxt = WAIT;
      WAIT: state_nxt = RUN;
      RUN:  if (it_done || (steps == LIMIT)) state_nxt = EMIT;
      EMIT: if (res_ready) state_nxt = (remaining == STEP_W'(1)) ? IDLE : GO;
      default: state_nxt = IDLE;
    endcase
  end

  // Sweep datapath: cursor, remaining count, step counter, result and finished flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur         <= '0;
      remaining   <= '0;
      steps       <= '0;
      res_n       <= '0;
      res_steps   <= '0;
      res_timeout <= 1'b0;
      finished    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (count != '0) begin
              cur       <= first;
              remaining <= count;
              finished  <= 1'b0;
            end else begin
              finished  <= 1'b1;
            end
          end
        end
        GO: steps <= '0;
        RUN: begin
          if (it_done) begin
            res_n       <= cur;
            res_steps   <= steps;
            res_timeout <= 1'b0;
          end else if (steps == LIMIT) begin
            res_n       <= cur;
            res_steps   <= steps;
            res_timeout <= 1'b1;
          end else begin
            steps <= steps + STEP_W'(1);
          end
        end
        EMIT: begin
          if (res_ready) begin
            cur       <= cur + N_W'(1);
            remaining <= remaining - STEP_W'(1);
            if (remaining == STEP_W'(1)) finished <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  collatz_max_tracker #(
    .N_W    (N_W),
    .STEP_W (STEP_W)
  ) u_max (
    .clk          (clk),
    .reset        (reset),
    .clear        (start_ok),
    .update       (accept),
    .cand_n       (res_n),
    .cand_steps   (res_steps),
    .cand_timeout (res_timeout),
    .max_n        (max_n),
    .max_steps    (max_steps)
  );

endmodule

// File: tb/tb_collatz_sweep.sv
// Bench for collatz_sweep: two instances (default limit and limit 50), each
// paired with a behavioural iterator; a scoreboard queue holds expected results.
module tb_collatz_sweep;

  localparam int unsigned LIM0 = 1000;
  localparam int unsigned LIM1 = 50;

  logic        clk;
  logic        reset;
  logic        start     [2];
  logic [31:0] first     [2];
  logic [15:0] count     [2];
  logic        it_go     [2];
  logic [31:0] it_n      [2];
  logic        it_done   [2];
  logic        res_valid [2];
  logic        res_ready [2];
  logic [31:0] res_n     [2];
  logic [15:0] res_steps [2];
  logic        res_timeout [2];
  logic        busy      [2];
  logic        finished  [2];
  logic [31:0] max_n     [2];
  logic [15:0] max_steps [2];
  logic [31:0] it_x      [2];

  typedef struct {
    logic [31:0] n;
    logic [15:0] steps;
    logic        to;
  } res_t;

  res_t        exp_q[$];
  res_t        e;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_extra = 0;
  int          sel     = 0;
  int          cyc     = 0;
  int          start_cyc = 0;
  int          lat     = 0;
  bit          seen_valid = 0;
  logic [31:0] exp_max_n;
  logic [15:0] exp_max_s;

  collatz_sweep #(.N_W(32), .STEP_W(16), .STEP_LIMIT(LIM0)) dut0 (
    .clk(clk), .reset(reset), .start(start[0]), .first(first[0]), .count(count[0]),
    .it_go(it_go[0]), .it_n(it_n[0]), .it_done(it_done[0]),
    .res_valid(res_valid[0]), .res_ready(res_ready[0]), .res_n(res_n[0]),
    .res_steps(res_steps[0]), .res_timeout(res_timeout[0]), .busy(busy[0]),
    .finished(finished[0]), .max_n(max_n[0]), .max_steps(max_steps[0])
  );

  collatz_sweep #(.N_W(32), .STEP_W(16), .STEP_LIMIT(LIM1)) dut1 (
    .clk(clk), .reset(reset), .start(start[1]), .first(first[1]), .count(count[1]),
    .it_go(it_go[1]), .it_n(it_n[1]), .it_done(it_done[1]),
    .res_valid(res_valid[1]), .res_ready(res_ready[1]), .res_n(res_n[1]),
    .res_steps(res_steps[1]), .res_timeout(res_timeout[1]), .busy(busy[1]),
    .finished(finished[1]), .max_n(max_n[1]), .max_steps(max_steps[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural iterator: load on go, done reflects the loaded value two edges later.
  for (genvar g = 0; g < 2; g++) begin : g_iter
    always @(posedge clk or posedge reset) begin
      if (reset) begin
        it_x[g]    <= '0;
        it_done[g] <= 1'b0;
      end else if (it_go[g]) begin
        it_x[g]    <= it_n[g];
        it_done[g] <= 1'b0;
      end else begin
        it_done[g] <= (it_x[g] == 32'd1);
        if (it_x[g] != 32'd1)
          it_x[g] <= it_x[g][0] ? (it_x[g] * 32'd3 + 32'd1) : (it_x[g] >> 1);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void ref_steps(input logic [31:0] n, input int unsigned limit,
                                    output logic [15:0] s, output logic to);
    logic [31:0] x;
    x = n;
    s = '0;
    to = 1'b0;
    for (int unsigned k = 0; k <= limit; k++) begin
      if (x == 32'd1) return;
      if (k == limit) begin
        to = 1'b1;
        return;
      end
      x = x[0] ? (x * 32'd3 + 32'd1) : (x >> 1);
      s = s + 16'd1;
    end
  endfunction

  // Scoreboard consumer: compare every accepted result against the queue head.
  always @(negedge clk) begin
    if (!reset && res_valid[sel] && !seen_valid) begin
      seen_valid = 1'b1;
      lat = cyc - start_cyc;
    end
    if (!reset && res_valid[sel] && res_ready[sel]) begin
      if (exp_q.size() == 0) begin
        n_extra++;
      end else begin
        e = exp_q.pop_front();
        check("res_n", res_n[sel], e.n);
        check("res_steps", res_steps[sel], e.steps);
        check("res_timeout", res_timeout[sel], e.to);
      end
    end
  end

  task automatic push_range(input int d, input logic [31:0] f, input logic [15:0] c);
    logic [15:0] s;
    logic        to;
    res_t        r;
    exp_max_n = '0;
    exp_max_s = '0;
    for (int unsigned i = 0; i < c; i++) begin
      r.n = f + i;
      ref_steps(r.n, (d == 0) ? LIM0 : LIM1, s, to);
      r.steps = s;
      r.to = to;
      exp_q.push_back(r);
      if (!to && (s > exp_max_s)) begin
        exp_max_n = r.n;
        exp_max_s = s;
      end
    end
  endtask

  task automatic pulse_start(input int d, input logic [31:0] f, input logic [15:0] c);
    @(posedge clk); #1;
    sel = d;
    first[d] = f;
    count[d] = c;
    start[d] = 1'b1;
    start_cyc = cyc;
    seen_valid = 1'b0;
    n_extra = 0;
    @(posedge clk); #1;
    start[d] = 1'b0;
  endtask

  task automatic wait_finished(input int d, input string tag);
    int k;
    k = 0;
    while (!finished[d] && k < 20000) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_finished"}, finished[d], 1);
    check({tag, "_busy"}, busy[d], 0);
    check({tag, "_pending"}, exp_q.size(), 0);
    check({tag, "_extra"}, n_extra, 0);
    check({tag, "_max_n"}, max_n[d], exp_max_n);
    check({tag, "_max_steps"}, max_steps[d], exp_max_s);
    exp_q.delete();
  endtask

  task automatic run_sweep(input int d, input logic [31:0] f, input logic [15:0] c,
                           input string tag);
    push_range(d, f, c);
    pulse_start(d, f, c);
    wait_finished(d, tag);
  endtask

  initial begin
    logic [31:0] hold_n;
    logic [15:0] hold_s;
    int          k;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0;
      first[i] = '0;
      count[i] = '0;
      res_ready[i] = 1'b1;
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_it_go", it_go[i], 0);
      check("rst_res_valid", res_valid[i], 0);
      check("rst_busy", busy[i], 0);
      check("rst_finished", finished[i], 0);
      check("rst_it_n", it_n[i], 0);
      check("rst_res", {res_n[i], res_steps[i], res_timeout[i]}, 0);
      check("rst_max", {max_n[i], max_steps[i]}, 0);
    end
    @(posedge clk); #1;
    reset = 1'b0;

    run_sweep(0, 32'd1, 16'd1, "one");
    check("one_latency", lat, 4);
    run_sweep(0, 32'd27, 16'd1, "n27");
    check("n27_max_n_const", max_n[0], 27);
    check("n27_max_steps_const", max_steps[0], 111);
    run_sweep(0, 32'd1, 16'd10, "range");
    check("range_max_n_const", max_n[0], 9);
    check("range_max_steps_const", max_steps[0], 19);
    run_sweep(1, 32'd27, 16'd2, "tmo");
    check("tmo_max_n_const", max_n[1], 28);
    run_sweep(1, 32'd0, 16'd1, "zero");

    // Backpressure: hold ready low five cycles once the first result appears.
    res_ready[0] = 1'b0;
    push_range(0, 32'd6, 16'd2);
    pulse_start(0, 32'd6, 16'd2);
    k = 0;
    while (!res_valid[0] && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("bp_valid", res_valid[0], 1);
    hold_n = res_n[0];
    hold_s = res_steps[0];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_n_stable", res_n[0], hold_n);
      check("bp_steps_stable", res_steps[0], hold_s);
      check("bp_valid_held", res_valid[0], 1);
      check("bp_no_go", it_go[0], 0);
      if (i == 2) begin
        first[0] = 32'd100;
        count[0] = 16'd3;
        start[0] = 1'b1;
      end
      if (i == 3) start[0] = 1'b0;
    end
    @(posedge clk); #1;
    res_ready[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_next_go", it_go[0], 1);
    check("bp_next_n", it_n[0], 7);
    wait_finished(0, "bp");

    // Reset in the middle of a sweep of 7.
    pulse_start(0, 32'd7, 16'd1);
    repeat (4) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("mid_rst_it_go", it_go[0], 0);
    check("mid_rst_busy", busy[0], 0);
    check("mid_rst_valid", res_valid[0], 0);
    check("mid_rst_finished", finished[0], 0);
    check("mid_rst_outs", {res_n[0], res_steps[0], res_timeout[0], it_n[0]}, 0);
    check("mid_rst_max", {max_n[0], max_steps[0]}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (25) @(negedge clk);
    check("mid_rst_no_result", n_extra, 0);
    check("mid_rst_idle_finished", finished[0], 0);

    // count=0 start: finished one cycle later, no results.
    @(posedge clk); #1;
    count[0] = 16'd0;
    first[0] = 32'd5;
    start[0] = 1'b1;
    n_extra = 0;
    @(negedge clk);
    check("cnt0_finished_early", finished[0], 0);
    @(posedge clk); #1;
    start[0] = 1'b0;
    @(negedge clk);
    check("cnt0_finished", finished[0], 1);
    check("cnt0_busy", busy[0], 0);
    repeat (5) @(negedge clk);
    check("cnt0_no_valid", res_valid[0], 0);
    check("cnt0_no_result", n_extra, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
